// File: rtl/slv_burst_arbiter_pkg.sv
// ip_arb_pkg: shared state, source and width definitions for the slave burst arbiter
package ip_arb_pkg;
    typedef enum logic [1:0] {IDLE, XFER, WAIT_CMPLT, DONE} arb_state_t;
    typedef enum logic {SRC0, SRC1} src_t;
    localparam int MODE_W = 2;
endpackage

// File: rtl/slv_burst_arbiter_rr_picker.sv
// rr_picker: combinational 2-way pick; a lone request wins outright, a tie goes to rr_ptr
module rr_picker
    import ip_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  src_t       rr_ptr_i,
    output logic       gnt_o,
    output src_t       src_o
);
    assign gnt_o = |req_i;
    assign src_o = (req_i == 2'b11) ? rr_ptr_i : src_t'(req_i[1]);
endmodule

// File: rtl/slv_burst_arbiter.sv
// slv_burst_arbiter: round-robin, burst-locked sharing of one processing engine between two slaves
module slv_burst_arbiter
    import ip_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LENW    = 8,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] slv0_mode,
    input  logic [MODE_W-1:0] slv1_mode,
    input  logic              slv0_data_valid,
    input  logic              slv1_data_valid,
    input  logic [LENW-1:0]   slv0_proc_valid,
    input  logic [LENW-1:0]   slv1_proc_valid,
    input  logic [DW-1:0]     slv0_data,
    input  logic [DW-1:0]     slv1_data,
    input  logic              proc_cmplt,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic [MODE_W-1:0] slvx_mode,
    output logic              slvx_data_valid,
    output logic [LENW-1:0]   slvx_proc_val,
    output logic [DW-1:0]     slvx_data,
    output logic              slv0_ready,
    output logic              slv1_ready,
    output logic              data_source,
    output logic              mstr0_cmplt
);
    arb_state_t        state_q, state_d;
    src_t              rr_q, rr_d, src_q, src_d, pick;
    logic              gnt, rdy, acc, g_valid, unused_ok;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [LENW-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic [DW-1:0]     data_q, data_d, g_data;
    logic              dval_q, dval_d;

    rr_picker u_pick (
        .req_i    ({slv1_data_valid, slv0_data_valid}),
        .rr_ptr_i (rr_q),
        .gnt_o    (gnt),
        .src_o    (pick)
    );

    assign unused_ok       = fifo_empty;
    assign rdy             = (state_q == XFER) && !fifo_full;
    assign g_valid         = (src_q == SRC1) ? slv1_data_valid : slv0_data_valid;
    assign g_data          = (src_q == SRC1) ? slv1_data : slv0_data;
    assign acc             = rdy && g_valid;
    assign slv0_ready      = rdy && (src_q == SRC0);
    assign slv1_ready      = rdy && (src_q == SRC1);
    assign slvx_mode       = mode_q;
    assign slvx_proc_val   = len_q;
    assign slvx_data       = data_q;
    assign slvx_data_valid = dval_q;
    assign data_source     = src_q;
    assign mstr0_cmplt     = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = acc ? g_data : data_q;
        dval_d  = acc;
        case (state_q)
            IDLE: if (gnt) begin
                state_d = XFER;
                src_d   = pick;
                mode_d  = (pick == SRC1) ? slv1_mode : slv0_mode;
                len_d   = (pick == SRC1) ? slv1_proc_valid : slv0_proc_valid;
                // a zero-length request still moves exactly one beat
                cnt_d   = (len_d == '0) ? LENW'(1) : len_d;
            end
            XFER: if (acc) begin
                cnt_d = cnt_q - LENW'(1);
                if (cnt_q == LENW'(1)) state_d = WAIT_CMPLT;
            end
            WAIT_CMPLT: if (proc_cmplt) state_d = DONE;
            DONE: begin
                rr_d    = src_t'(~src_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= src_t'(RR_INIT);
            src_q   <= SRC0;
            mode_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
        end
    end
endmodule

// File: tb/tb_slv_burst_arbiter.sv
// tb_slv_burst_arbiter: directed scenario tests for slv_burst_arbiter
module tb_slv_burst_arbiter;
    logic        clk = 0, rst = 1;
    logic [1:0]  slv0_mode = 0, slv1_mode = 0, slvx_mode;
    logic        slv0_data_valid = 0, slv1_data_valid = 0;
    logic [7:0]  slv0_proc_valid = 0, slv1_proc_valid = 0, slvx_proc_val;
    logic [31:0] slv0_data = 0, slv1_data = 0, slvx_data;
    logic        proc_cmplt = 0, fifo_full = 0, fifo_empty = 1;
    logic        slvx_data_valid, slv0_ready, slv1_ready, data_source, mstr0_cmplt;
    logic [31:0] got[$];
    int          errors = 0, checks = 0;

    slv_burst_arbiter dut (
        .clk(clk), .rst(rst),
        .slv0_mode(slv0_mode), .slv1_mode(slv1_mode),
        .slv0_data_valid(slv0_data_valid), .slv1_data_valid(slv1_data_valid),
        .slv0_proc_valid(slv0_proc_valid), .slv1_proc_valid(slv1_proc_valid),
        .slv0_data(slv0_data), .slv1_data(slv1_data),
        .proc_cmplt(proc_cmplt), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .slvx_mode(slvx_mode), .slvx_data_valid(slvx_data_valid),
        .slvx_proc_val(slvx_proc_val), .slvx_data(slvx_data),
        .slv0_ready(slv0_ready), .slv1_ready(slv1_ready),
        .data_source(data_source), .mstr0_cmplt(mstr0_cmplt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (slvx_data_valid === 1'b1) got.push_back(slvx_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pump(input bit s, input int n, input logic [15:0] ff, output int acc);
        logic r;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            fifo_full = ff[i];
            #1;
            r = s ? slv1_ready : slv0_ready;
            tick();
            if (r) begin
                acc++;
                if (s) slv1_data++;
                else slv0_data++;
            end
        end
        fifo_full = 0;
    endtask

    task automatic finish_burst();
        proc_cmplt = 1;
        tick();
        proc_cmplt = 0;
        tick();
    endtask

    task automatic test_reset();
        checks++; if (slv0_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy0 got=%0b exp=0", slv0_ready); end
        checks++; if (slv1_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy1 got=%0b exp=0", slv1_ready); end
        checks++; if (slvx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_dval got=%0b exp=0", slvx_data_valid); end
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL rst_cmplt got=%0b exp=0", mstr0_cmplt); end
        checks++; if (data_source !== 1'b0) begin errors++; $display("FAIL rst_src got=%0b exp=0", data_source); end
        checks++; if (slvx_mode !== 2'd0 || slvx_proc_val !== 8'd0 || slvx_data !== 32'd0) begin
            errors++; $display("FAIL rst_regs got mode=%0d len=%0d data=%0h exp=0", slvx_mode, slvx_proc_val, slvx_data);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_single();
        int a, b;
        got.delete();
        slv0_mode = 2; slv0_proc_valid = 4; slv0_data = 32'hA0; slv0_data_valid = 1;
        tick();
        checks++; if (slvx_mode !== 2'd2 || slvx_proc_val !== 8'd4) begin errors++; $display("FAIL single_latch got mode=%0d len=%0d exp 2/4", slvx_mode, slvx_proc_val); end
        checks++; if (slv0_ready !== 1'b1 || slv1_ready !== 1'b0) begin errors++; $display("FAIL single_rdy got %0b%0b exp 01", slv1_ready, slv0_ready); end
        checks++; if (slvx_data_valid !== 1'b0) begin errors++; $display("FAIL single_idle_beat got=%0b exp=0", slvx_data_valid); end
        slv0_mode = 1; slv0_proc_valid = 9;
        pump(0, 1, 16'h0, a);
        checks++; if (slvx_data_valid !== 1'b1 || slvx_data !== 32'hA0) begin errors++; $display("FAIL single_first got v=%0b d=%0h exp 1/a0", slvx_data_valid, slvx_data); end
        pump(0, 6, 16'h0, b);
        checks++; if (a + b !== 4) begin errors++; $display("FAIL single_accepts got=%0d exp=4", a + b); end
        checks++; if (slvx_mode !== 2'd2 || slvx_proc_val !== 8'd4) begin errors++; $display("FAIL single_hold got mode=%0d len=%0d exp 2/4", slvx_mode, slvx_proc_val); end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL single_nbeats got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got.size() <= i || got[i] !== 32'hA0 + i) begin errors++; $display("FAIL single_beat%0d exp=%0h", i, 32'hA0 + i); end
        end
        slv0_data_valid = 0;
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL single_wait_cmplt got=%0b exp=0", mstr0_cmplt); end
        proc_cmplt = 1;
        tick();
        proc_cmplt = 0;
        checks++; if (mstr0_cmplt !== 1'b1) begin errors++; $display("FAIL single_cmplt got=%0b exp=1", mstr0_cmplt); end
        tick();
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL single_cmplt_pulse got=%0b exp=0", mstr0_cmplt); end
    endtask

    task automatic test_tie();
        int a;
        rst = 1; tick(); rst = 0;
        got.delete();
        slv0_data = 10; slv1_data = 20; slv0_proc_valid = 1; slv1_proc_valid = 1;
        slv0_data_valid = 1; slv1_data_valid = 1;
        tick();
        checks++; if (data_source !== 1'b0 || slv1_ready !== 1'b0) begin errors++; $display("FAIL tie_first got src=%0b rdy1=%0b exp 0/0", data_source, slv1_ready); end
        pump(0, 2, 16'h0, a);
        finish_burst();
        tick();
        checks++; if (data_source !== 1'b1 || slv0_ready !== 1'b0) begin errors++; $display("FAIL tie_second got src=%0b rdy0=%0b exp 1/0", data_source, slv0_ready); end
        pump(1, 2, 16'h0, a);
        finish_burst();
        tick();
        checks++; if (data_source !== 1'b0) begin errors++; $display("FAIL tie_third got src=%0b exp=0", data_source); end
        pump(0, 2, 16'h0, a);
        slv0_data_valid = 0; slv1_data_valid = 0;
        finish_burst();
        checks++; if (got.size() !== 3 || got[0] !== 32'd10 || got[1] !== 32'd20 || got[2] !== 32'd11) begin
            errors++; $display("FAIL tie_order got n=%0d exp 10,20,11", got.size());
        end
    endtask

    task automatic test_backpressure();
        int a;
        got.delete();
        slv1_proc_valid = 5; slv1_data = 32'h100; slv1_mode = 1; slv1_data_valid = 1;
        tick();
        fifo_full = 1; #1;
        checks++; if (slv1_ready !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got=%0b exp=0", slv1_ready); end
        fifo_full = 0; #1;
        checks++; if (slv1_ready !== 1'b1) begin errors++; $display("FAIL bp_free_rdy got=%0b exp=1", slv1_ready); end
        pump(1, 8, 16'b0110, a);
        slv1_data_valid = 0;
        checks++; if (a !== 5) begin errors++; $display("FAIL bp_accepts got=%0d exp=5", a); end
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL bp_nbeats got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got.size() <= i || got[i] !== 32'h100 + i) begin errors++; $display("FAIL bp_beat%0d exp=%0h", i, 32'h100 + i); end
        end
        finish_burst();
    endtask

    task automatic test_zero_len();
        int a;
        got.delete();
        slv0_proc_valid = 0; slv0_data = 32'h55; slv0_data_valid = 1;
        tick();
        pump(0, 4, 16'h0, a);
        slv0_data_valid = 0;
        checks++; if (a !== 1 || got.size() !== 1) begin errors++; $display("FAIL zero_len got acc=%0d beats=%0d exp 1/1", a, got.size()); end
        proc_cmplt = 1; tick(); proc_cmplt = 0;
        checks++; if (mstr0_cmplt !== 1'b1) begin errors++; $display("FAIL zero_len_cmplt got=%0b exp=1", mstr0_cmplt); end
        tick();
    endtask

    task automatic test_mid_reset();
        int a;
        slv0_mode = 3; slv0_proc_valid = 6; slv0_data = 32'h200; slv0_data_valid = 1;
        tick();
        pump(0, 2, 16'h0, a);
        checks++; if (a !== 2) begin errors++; $display("FAIL mr_pre got=%0d exp=2", a); end
        rst = 1; #1;
        checks++; if (slvx_data_valid !== 1'b0 || slv0_ready !== 1'b0) begin errors++; $display("FAIL mr_async got v=%0b rdy=%0b exp 0/0", slvx_data_valid, slv0_ready); end
        checks++; if (slvx_mode !== 2'd0 || slvx_proc_val !== 8'd0 || slvx_data !== 32'd0) begin errors++; $display("FAIL mr_regs got mode=%0d len=%0d exp 0/0", slvx_mode, slvx_proc_val); end
        slv0_data_valid = 0;
        tick();
        rst = 0;
        got.delete();
        proc_cmplt = 1; tick(); proc_cmplt = 0;
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL mr_idle_cmplt got=%0b exp=0", mstr0_cmplt); end
        tick();
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL mr_no_cmplt got=%0b exp=0", mstr0_cmplt); end
        slv0_proc_valid = 2; slv0_data = 32'h300; slv0_data_valid = 1;
        tick();
        checks++; if (slvx_mode !== 2'd3 || slvx_proc_val !== 8'd2) begin errors++; $display("FAIL mr_next_latch got mode=%0d len=%0d exp 3/2", slvx_mode, slvx_proc_val); end
        pump(0, 3, 16'h0, a);
        slv0_data_valid = 0;
        checks++; if (a !== 2 || got.size() !== 2 || got[0] !== 32'h300 || got[1] !== 32'h301) begin
            errors++; $display("FAIL mr_next_beats got acc=%0d n=%0d exp 2 beats 300,301", a, got.size());
        end
        finish_burst();
    endtask

    task automatic test_early_late_cmplt();
        int a;
        slv1_proc_valid = 3; slv1_data = 32'h400; slv1_data_valid = 1;
        tick();
        fifo_full = 1; proc_cmplt = 1;
        tick();
        proc_cmplt = 0; fifo_full = 0; #1;
        checks++; if (mstr0_cmplt !== 1'b0 || slv1_ready !== 1'b1) begin errors++; $display("FAIL early_cmplt got cmplt=%0b rdy=%0b exp 0/1", mstr0_cmplt, slv1_ready); end
        pump(1, 3, 16'h0, a);
        slv1_data_valid = 0;
        checks++; if (a !== 3) begin errors++; $display("FAIL late_accepts got=%0d exp=3", a); end
        proc_cmplt = 1; tick(); proc_cmplt = 0;
        checks++; if (mstr0_cmplt !== 1'b1) begin errors++; $display("FAIL late_cmplt got=%0b exp=1", mstr0_cmplt); end
        tick();
        checks++; if (mstr0_cmplt !== 1'b0) begin errors++; $display("FAIL late_cmplt_pulse got=%0b exp=0", mstr0_cmplt); end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_zero_len();
        test_mid_reset();
        test_early_late_cmplt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
